dilithium_stream_adapter: RTL

Parametrised host-to-core adapter for the Dilithium accelerator: a successor to the fixed 32-bit low-resource adapter, generalised to a HOST_W-bit host bus with output buffering and per-mode completion tracking. It accepts a start/mode command, issues the operation code to the 32-bit Dilithium core, serialises host input words into core words, and packs core output words into host words through an internal FIFO. It asserts `done` once the mode's full output length has been delivered to the host.

---
 rtl/dilithium_stream_adapter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dilithium_stream_adapter.sv
// -----------------------------------------------------------------------------
// dilithium_stream_adapter
//
// Host-to-core adapter for the Dilithium accelerator. A start/mode command is
// turned into a core operation code. HOST_W-bit host input words are split into
// 32-bit core words, least significant lane first. 32-bit core output words are
// buffered in a FIFO and packed back into host words. done pulses once the
// mode's full output length has reached the host.
//
// Parameters
//   HOST_W        host data width: 32, 64 or 128 (R = HOST_W/32 lanes)
//   FIFO_DEPTH    output FIFO depth in core words (power of two, >= 2*R)
//   KG/SG/VF_OUT_WORDS  core words produced by keygen / sign / verify
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, mode                   command strobe (IDLE only), 0 kg 1 sg 2 vf 3 bad
//   busy, err, done               status: busy level, illegal-mode pulse, done pulse
//   valid_i, ready_i, data_i      host input stream
//   valid_o, ready_o, data_o      host output stream
//   op, op_valid, op_ready        core command, op = {2'b00, mode}
//   core_data_in/valid_in/ready_in     core input stream
//   core_data_out/valid_out/ready_out  core output stream
//
// Optional feature: define DILITHIUM_ADAPTER_PERF_EN to add perf_cycles, a
// saturating count of busy cycles, cleared on every accepted start.
// -----------------------------------------------------------------------------
module dilithium_stream_adapter #(
  parameter int HOST_W       = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int KG_OUT_WORDS = 960,
  parameter int SG_OUT_WORDS = 605,
  parameter int VF_OUT_WORDS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              err,
  output logic              done,
  input  logic              valid_i,
  output logic              ready_i,
  input  logic [HOST_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_o,
  output logic [HOST_W-1:0] data_o,
  output logic [3:0]        op,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [31:0]       core_data_in,
  output logic              core_valid_in,
  input  logic              core_ready_in,
  input  logic [31:0]       core_data_out,
  input  logic              core_valid_out,
  output logic              core_ready_out
`ifdef DILITHIUM_ADAPTER_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int R  = HOST_W / 32;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [15:0]       target_q, mode_target, out_cnt;
  logic [HOST_W-1:0] in_buf;
  logic [2:0]        in_cnt;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt, pop_n;
  logic [HOST_W-1:0] pack_data;
  logic              start_ok, illegal, core_all, push, load_ok, flush_done;

  assign start_ok = (state_q == S_IDLE) && start && (mode != 2'd3);
  assign illegal  = (state_q == S_IDLE) && start && (mode == 2'd3);
  assign core_all = (out_cnt == target_q);
  assign push     = core_valid_out && core_ready_out;

  assign busy           = (state_q != S_IDLE);
  assign op_valid       = (state_q == S_CMD);
  assign op             = {2'b00, mode_q};
  assign ready_i        = (state_q == S_RUN) && (in_cnt == 3'd0);
  assign core_valid_in  = (state_q == S_RUN) && (in_cnt != 3'd0);
  assign core_data_in   = in_buf[31:0];
  assign core_ready_out = (state_q == S_RUN) && (fifo_cnt != CW'(FIFO_DEPTH)) &&
                          (out_cnt < target_q);

  always_comb begin
    mode_target = 16'(KG_OUT_WORDS);
    case (mode)
      2'd1:    mode_target = 16'(SG_OUT_WORDS);
      2'd2:    mode_target = 16'(VF_OUT_WORDS);
      default: ;
    endcase
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_CMD;
      S_CMD:   if (op_ready) state_d = S_RUN;
      S_RUN:   if (core_all) state_d = S_FLUSH;
      S_FLUSH: begin
        // Leave once the FIFO is drained and the last host word is taken.
        if ((fifo_cnt == '0) && (!valid_o || ready_o)) begin
          state_d    = S_IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values seen before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      target_q <= 16'd0;
      out_cnt  <= 16'd0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      err     <= illegal;
      done    <= flush_done;
      if (start_ok) begin
        mode_q   <= mode;
        target_q <= mode_target;
        out_cnt  <= 16'd0;
      end else if (push) begin
        out_cnt <= out_cnt + 16'd1;
      end
    end
  end

  // Input lane register: one host word, shifted down one lane per core
  // handshake. Anything still pending when RUN ends is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_buf <= '0;
      in_cnt <= 3'd0;
    end else if (state_q != S_RUN) begin
      in_cnt <= 3'd0;
    end else if (valid_i && ready_i) begin
      in_buf <= data_i;
      in_cnt <= 3'(R);
    end else if (core_valid_in && core_ready_in) begin
      in_buf <= in_buf >> 32;
      in_cnt <= in_cnt - 3'd1;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count alone define
  // which entries are meaningful, so stale contents after reset are harmless.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= core_data_out;
  end

  // Packer: take a full group of R words, or whatever remains once the core
  // has delivered its last word, with the missing upper lanes left at zero.
  always_comb begin
    load_ok   = !valid_o || ready_o;
    pop_n     = '0;
    pack_data = '0;
    if (load_ok) begin
      if (fifo_cnt >= CW'(R)) pop_n = CW'(R);
      else if (core_all)      pop_n = fifo_cnt;
    end
    for (int i = 0; i < R; i++) begin
      if (CW'(i) < pop_n) pack_data[32*i +: 32] = mem[rd_ptr + AW'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      valid_o  <= 1'b0;
      data_o   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr + AW'(pop_n);
      fifo_cnt <= fifo_cnt + CW'(push) - pop_n;
      if (load_ok) begin
        valid_o <= (pop_n != '0);
        if (pop_n != '0) data_o <= pack_data;
      end
    end
  end

`ifdef DILITHIUM_ADAPTER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    perf_cycles <= 32'd0;
    else if (start_ok)             perf_cycles <= 32'd0;
    else if (busy && (perf_cycles != 32'hFFFF_FFFF))
                                   perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule
